// File: rtl/frame_scheduler_pkg.sv
// Shared constants and state encoding for the double-buffered frame scheduler.
// The CLEAR state is only reachable when FRAME_SCHEDULER_SKY_CLEAR_EN is defined.
package frame_scheduler_pkg;

    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int FB_ADDR_W = 18;

    typedef enum logic [1:0] {
        ST_CLEAR     = 2'd0,
        ST_START     = 2'd1,
        ST_RENDER    = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } state_e;

endpackage

// File: rtl/frame_scheduler_if.sv
// Renderer handshake plus framebuffer write port; master is the scheduler side.
interface frame_scheduler_if;
    import frame_scheduler_pkg::*;

    logic                 render_ack;
    logic                 render_done;
    logic                 rend_we;
    logic [8:0]           rend_x;
    logic [7:0]           rend_y;
    logic [7:0]           rend_color;
    logic                 fb_we;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [7:0]           fb_color;

    modport master (
        output render_ack, fb_we, fb_addr, fb_color,
        input  render_done, rend_we, rend_x, rend_y, rend_color
    );

    modport slave (
        input  render_ack, fb_we, fb_addr, fb_color,
        output render_done, rend_we, rend_x, rend_y, rend_color
    );
endinterface

// File: rtl/frame_scheduler_fb_addr_gen.sv
// Combinational framebuffer address: {buffer select, y*320 + x}.
// y*320 is built from two shifts so no multiplier is inferred.
module fb_addr_gen
    import frame_scheduler_pkg::*;
(
    input  logic                 buf_sel,
    input  logic [8:0]           x,
    input  logic [7:0]           y,
    output logic [FB_ADDR_W-1:0] addr
);
    logic [16:0] y_x320;

    assign y_x320 = {1'b0, y, 8'b0} + {3'b0, y, 6'b0};
    assign addr   = {buf_sel, y_x320 + {8'b0, x}};
endmodule

// File: rtl/frame_scheduler.sv
// Double-buffer frame scheduler: optional sky clear, renderer handshake, vsync swap.
// Define FRAME_SCHEDULER_SKY_CLEAR_EN to include the CLEAR pass over the back buffer.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter logic [7:0] SKY_COLOR = 8'h00
)
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               vsync,
    frame_scheduler_if.master  bus,
    output logic               front_buf,
    output logic [15:0]        frame_count,
    output logic [7:0]         late_frames
);
    localparam logic [1:0] START     = 2'(ST_START);
    localparam logic [1:0] RENDER    = 2'(ST_RENDER);
    localparam logic [1:0] WAIT_SWAP = 2'(ST_WAIT_SWAP);
`ifdef FRAME_SCHEDULER_SKY_CLEAR_EN
    localparam logic [1:0] CLEAR     = 2'(ST_CLEAR);
    localparam logic [1:0] RESTART   = CLEAR;
`else
    localparam logic [1:0] RESTART   = START;
`endif

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]           state;
    logic                 vsync_q;
    logic                 vsync_edge;
    logic                 back_buf;
    logic [8:0]           sel_x;
    logic [7:0]           sel_y;
    logic                 wr_p0;
    logic [7:0]           color_p0;
    logic [FB_ADDR_W-1:0] addr_p0;
    logic                 fb_we_p1;
    logic [FB_ADDR_W-1:0] fb_addr_p1;
    logic [7:0]           fb_color_p1;
    logic                 render_ack_p1;

    assign vsync_edge = vsync & ~vsync_q;
    assign back_buf   = ~front_buf;

`ifdef FRAME_SCHEDULER_SKY_CLEAR_EN
    logic [8:0] clr_x;
    logic [7:0] clr_y;
    logic       clr_last;
    logic       in_clear;

    assign in_clear = (state == CLEAR);
    assign clr_last = (clr_x == 9'(SCREEN_W - 1)) && (clr_y == 8'(SCREEN_H - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            clr_x <= '0;
            clr_y <= '0;
        end else if (in_clear) begin
            if (clr_x == 9'(SCREEN_W - 1)) begin
                clr_x <= '0;
                clr_y <= clr_last ? 8'd0 : clr_y + 8'd1;
            end else begin
                clr_x <= clr_x + 9'd1;
            end
        end
    end

    // Clear counters own the shared address generator while clearing.
    always_comb begin
        sel_x    = in_clear ? clr_x : bus.rend_x;
        sel_y    = in_clear ? clr_y : bus.rend_y;
        color_p0 = in_clear ? SKY_COLOR : bus.rend_color;
        wr_p0    = in_clear | ((state == RENDER) & bus.rend_we);
    end
`else
    logic unused_sky;

    assign unused_sky = ^SKY_COLOR;

    always_comb begin
        sel_x    = bus.rend_x;
        sel_y    = bus.rend_y;
        color_p0 = bus.rend_color;
        wr_p0    = (state == RENDER) & bus.rend_we;
    end
`endif

    fb_addr_gen u_addr_gen (
        .buf_sel (back_buf),
        .x       (sel_x),
        .y       (sel_y),
        .addr    (addr_p0)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= RESTART;
            vsync_q       <= 1'b1;
            front_buf     <= 1'b0;
            frame_count   <= '0;
            late_frames   <= '0;
            render_ack_p1 <= 1'b0;
        end else begin
            vsync_q       <= vsync;
            render_ack_p1 <= (state == START);
            // An edge outside WAIT_SWAP means the back frame missed this refresh.
            if (vsync_edge) begin
                if (state == WAIT_SWAP) begin
                    front_buf   <= ~front_buf;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    late_frames <= sat_inc8(late_frames);
                end
            end
            case (state)
`ifdef FRAME_SCHEDULER_SKY_CLEAR_EN
                CLEAR:     if (clr_last) state <= START;
`endif
                START:     state <= RENDER;
                RENDER:    if (bus.render_done) state <= WAIT_SWAP;
                WAIT_SWAP: if (vsync_edge) state <= RESTART;
                default:   state <= RESTART;
            endcase
        end
    end

    // ---- write port register stage (p0 -> p1) ----
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fb_we_p1    <= 1'b0;
            fb_addr_p1  <= '0;
            fb_color_p1 <= '0;
        end else begin
            fb_we_p1 <= wr_p0;
            if (wr_p0) begin
                fb_addr_p1  <= addr_p0;
                fb_color_p1 <= color_p0;
            end
        end
    end

    assign bus.fb_we      = fb_we_p1;
    assign bus.fb_addr    = fb_addr_p1;
    assign bus.fb_color   = fb_color_p1;
    assign bus.render_ack = render_ack_p1;
endmodule
